alu: RTL and testbench

- RV32IM integer ALU for the EX stage of the pipelined CPU.
- Base RV32I register/immediate ops are combinational and complete in the issue cycle.
- M-extension ops (MUL*/DIV*/REM*) are multi-cycle; completion is signalled on `done`.
- The CPU holds operands stable in EX registers until `done` lets the instruction advance.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_muldiv.sv | 159 +++++++++++++++
 rtl/alu.sv | 70 +++++++
 tb/tb_alu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings, FSM states and small helpers for the RV32IM EX-stage ALU.
package alu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  // Two's-complement negate when requested; used for magnitude and sign fix-up.
  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? XLEN'(~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Multi-cycle M-extension unit: single-cycle registered multiply, 32-step restoring divide.
module alu_muldiv
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_ready,
  input  logic            i_mop,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_valid_c,
  output logic            o_busy_c,
  output logic [XLEN-1:0] o_result
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_held;
  logic [XLEN-1:0]   r_result;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dsr;
  logic [XLEN-1:0]   r_a;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_div0;
  logic              r_is_rem;
  logic              w_finish;

  logic              w_start_mul;
  logic              w_start_div;
  logic              w_a_signed;
  logic              w_b_signed;
  logic [2*XLEN-1:0] w_mul_a;
  logic [2*XLEN-1:0] w_mul_b;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;
  logic              w_div_a_neg;
  logic              w_div_b_neg;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic [XLEN-1:0]   w_div_res;

  assign w_start_mul = i_ready && i_mop && !i_funct3[2];
  assign w_start_div = i_ready && i_mop &&  i_funct3[2];

  // Operand extension selects MUL/MULH/MULHSU/MULHU from one 64-bit product.
  assign w_a_signed = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU);
  assign w_b_signed = (i_funct3 == F3_MULH);
  assign w_mul_a    = {{XLEN{w_a_signed & i_a[XLEN-1]}}, i_a};
  assign w_mul_b    = {{XLEN{w_b_signed & i_b[XLEN-1]}}, i_b};
  assign w_prod     = w_mul_a * w_mul_b;
  assign w_mul_res  = (i_funct3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  assign w_div_a_neg = !i_funct3[0] && i_a[XLEN-1];
  assign w_div_b_neg = !i_funct3[0] && i_b[XLEN-1];

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_ge      = w_shift >= {1'b0, r_dsr};
  assign w_rem_nxt = w_ge ? XLEN'(w_shift - {1'b0, r_dsr}) : w_shift[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

  always_comb begin
    w_div_res = neg_if(r_neg_q, w_quo_nxt);
    if (r_div0) begin
      w_div_res = r_is_rem ? r_a : '1;
    end else if (r_is_rem) begin
      w_div_res = neg_if(r_neg_r, w_rem_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and status; a ready pulse always restarts from the new operands.
  always_comb begin
    w_state_nxt = r_state;
    o_valid_c   = 1'b0;
    o_busy_c    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: o_valid_c = r_held;
      MUL: begin
        o_valid_c   = 1'b1;
        w_state_nxt = IDLE;
      end
      DIV: begin
        o_busy_c = 1'b1;
        if (r_cnt == CNT_W'(XLEN - 1)) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (i_ready) begin
      w_state_nxt = i_mop ? (i_funct3[2] ? DIV : MUL) : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_held   <= 1'b0;
      r_result <= '0;
    end else if (i_ready) begin
      r_held <= 1'b0;
      if (w_start_mul) begin
        r_result <= w_mul_res;
      end
    end else if (r_state == MUL) begin
      r_held <= 1'b1;
    end else if (w_finish) begin
      r_held   <= 1'b1;
      r_result <= w_div_res;
    end
  end

  // Divider datapath operates on magnitudes; signs are re-applied on the last step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dsr    <= '0;
      r_a      <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_is_rem <= 1'b0;
    end else if (w_start_div) begin
      r_rem    <= '0;
      r_quo    <= neg_if(w_div_a_neg, i_a);
      r_dsr    <= neg_if(w_div_b_neg, i_b);
      r_a      <= i_a;
      r_cnt    <= '0;
      r_neg_q  <= w_div_a_neg ^ w_div_b_neg;
      r_neg_r  <= w_div_a_neg;
      r_div0   <= (i_b == '0);
      r_is_rem <= i_funct3[1];
    end else if (r_state == DIV) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/alu.sv
// RV32IM EX-stage ALU: combinational base ops, multi-cycle M ops, result/done muxing.
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        is_imm,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        ready,
  output logic [31:0] out,
  output logic        done
);

  logic            w_mop;
  logic            w_alt;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_base;
  logic            w_md_valid;
  logic            w_md_busy;
  logic [XLEN-1:0] w_md_result;

  assign w_mop   = !is_imm && (funct7 == F7_MULDIV);
  assign w_alt   = |(funct7 & F7_ALT);
  assign w_shamt = in2[4:0];

  always_comb begin
    w_base = '0;
    case (funct3)
      F3_ADD:  w_base = (!is_imm && w_alt) ? (in1 - in2) : (in1 + in2);
      F3_SLL:  w_base = in1 << w_shamt;
      F3_SLT:  w_base = XLEN'($signed(in1) < $signed(in2));
      F3_SLTU: w_base = XLEN'(in1 < in2);
      F3_XOR:  w_base = in1 ^ in2;
      F3_SR:   w_base = w_alt ? XLEN'($signed(in1) >>> w_shamt) : (in1 >> w_shamt);
      F3_OR:   w_base = in1 | in2;
      F3_AND:  w_base = in1 & in2;
      default: w_base = '0;
    endcase
  end

  alu_muldiv u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_ready  (ready),
    .i_mop    (w_mop),
    .i_funct3 (funct3),
    .i_a      (in1),
    .i_b      (in2),
    .o_valid_c(w_md_valid),
    .o_busy_c (w_md_busy),
    .o_result (w_md_result)
  );

  // A new ready pulse takes priority; otherwise show a held M result or the live base op.
  always_comb begin
    out  = w_base;
    done = 1'b1;
    if (ready) begin
      done = !w_mop;
    end else if (w_md_valid) begin
      out = w_md_result;
    end else if (w_md_busy) begin
      done = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed table, reset/hold sequences, random ops vs a reference model.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        is_imm;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        ready;
  logic [31:0] out;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  alu dut (
    .clk   (clk),
    .rst   (rst),
    .in1   (in1),
    .in2   (in2),
    .is_imm(is_imm),
    .funct3(funct3),
    .funct7(funct7),
    .ready (ready),
    .out   (out),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  function automatic vec_t mk(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic imm, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] exp, input int lat);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.imm = imm; v.f3 = f3; v.f7 = f7;
    v.exp = exp; v.lat = lat;
    return v;
  endfunction

  // Reference result computed directly from the RV32IM arithmetic definitions.
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic imm, input logic [2:0] f3,
                                             input logic [6:0] f7);
    longint          sa, sb, ub_s, sp;
    longint unsigned ua, ub, up;
    int              ia, ib;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    ub_s = longint'(b);
    ia = $signed(a);
    ib = $signed(b);
    r = 32'h0;
    if (!imm && f7 == 7'b0000001) begin
      case (f3)
        3'd0: begin sp = sa * sb;   r = sp[31:0];  end
        3'd1: begin sp = sa * sb;   r = sp[63:32]; end
        3'd2: begin sp = sa * ub_s; r = sp[63:32]; end
        3'd3: begin up = ua * ub;   r = up[63:32]; end
        3'd4: if (b == 0) r = 32'hFFFFFFFF;
              else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
              else r = ia / ib;
        3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
        3'd6: if (b == 0) r = a;
              else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
              else r = ia % ib;
        default: r = (b == 0) ? a : a % b;
      endcase
    end else begin
      case (f3)
        3'd0: r = (!imm && f7[5]) ? a - b : a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = (ia < ib) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
    return r;
  endfunction

  function automatic int ref_latency(input logic imm, input logic [2:0] f3, input logic [6:0] f7);
    if (imm || f7 != 7'b0000001) return 0;
    return f3[2] ? 33 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Issue one op with a ready pulse, then check done timing and the result.
  task automatic run_op(input vec_t v);
    int cyc;
    @(posedge clk); #1;
    in1 = v.a; in2 = v.b; is_imm = v.imm; funct3 = v.f3; funct7 = v.f7; ready = 1'b1;
    @(negedge clk);
    if (v.lat == 0) begin
      chk({v.name, " done"}, 32'(done), 32'd1);
      chk(v.name, out, v.exp);
      @(posedge clk); #1 ready = 1'b0;
    end else begin
      chk({v.name, " done0"}, 32'(done), 32'd0);
      @(posedge clk); #1 ready = 1'b0;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (done !== 1'b1 && cyc < 40);
      chk({v.name, " latency"}, 32'(cyc), 32'(v.lat));
      chk(v.name, out, v.exp);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom();
    endcase
  endfunction

  vec_t tbl[16];
  vec_t v;

  initial begin
    rst = 1'b0; ready = 1'b0; is_imm = 1'b0;
    in1 = 32'd5; in2 = 32'd7; funct3 = 3'b000; funct7 = 7'b0000000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset done", 32'(done), 32'd1);
    chk("reset idle add", out, 32'd12);

    tbl[0]  = mk("add",     32'd5,        32'd7,        1'b0, 3'b000, 7'b0000000, 32'd12,       0);
    tbl[1]  = mk("sub",     32'd3,        32'd5,        1'b0, 3'b000, 7'b0100000, 32'hFFFFFFFE, 0);
    tbl[2]  = mk("addi",    32'd3,        32'd5,        1'b1, 3'b000, 7'b0100000, 32'd8,        0);
    tbl[3]  = mk("sra",     32'h80000000, 32'd4,        1'b0, 3'b101, 7'b0100000, 32'hF8000000, 0);
    tbl[4]  = mk("srl",     32'h80000000, 32'd4,        1'b0, 3'b101, 7'b0000000, 32'h08000000, 0);
    tbl[5]  = mk("srai",    32'h80000000, 32'd4,        1'b1, 3'b101, 7'b0100000, 32'hF8000000, 0);
    tbl[6]  = mk("slt",     32'hFFFFFFFF, 32'd1,        1'b0, 3'b010, 7'b0000000, 32'd1,        0);
    tbl[7]  = mk("sltu",    32'hFFFFFFFF, 32'd1,        1'b0, 3'b011, 7'b0000000, 32'd0,        0);
    tbl[8]  = mk("mulh",    32'h80000000, 32'd2,        1'b0, 3'b001, 7'b0000001, 32'hFFFFFFFF, 1);
    tbl[9]  = mk("mulhu",   32'h80000000, 32'd2,        1'b0, 3'b011, 7'b0000001, 32'h00000001, 1);
    tbl[10] = mk("div",     32'hFFFFFFF9, 32'd2,        1'b0, 3'b100, 7'b0000001, 32'hFFFFFFFD, 33);
    tbl[11] = mk("rem",     32'hFFFFFFF9, 32'd2,        1'b0, 3'b110, 7'b0000001, 32'hFFFFFFFF, 33);
    tbl[12] = mk("divu0",   32'h00001234, 32'd0,        1'b0, 3'b101, 7'b0000001, 32'hFFFFFFFF, 33);
    tbl[13] = mk("divovf",  32'h80000000, 32'hFFFFFFFF, 1'b0, 3'b100, 7'b0000001, 32'h80000000, 33);
    tbl[14] = mk("rem0",    32'hFFFFFFF9, 32'd0,        1'b0, 3'b110, 7'b0000001, 32'hFFFFFFF9, 33);
    tbl[15] = mk("removf",  32'h80000000, 32'hFFFFFFFF, 1'b0, 3'b110, 7'b0000001, 32'h00000000, 33);
    for (int i = 0; i < 16; i++) run_op(tbl[i]);

    // Reset in the middle of a divide, then confirm the unit is idle and usable.
    @(posedge clk); #1;
    in1 = 32'd1000; in2 = 32'd7; is_imm = 1'b0; funct3 = 3'b101; funct7 = 7'b0000001; ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    in1 = 32'd5; in2 = 32'd7; funct3 = 3'b000; funct7 = 7'b0000000;
    @(negedge clk);
    chk("post-reset done", 32'(done), 32'd1);
    chk("post-reset out", out, 32'd12);
    repeat (30) @(negedge clk);
    chk("post-reset late done", 32'(done), 32'd1);
    chk("post-reset late out", out, 32'd12);

    run_op(mk("mul after reset", 32'd6, 32'd7, 1'b0, 3'b000, 7'b0000001, 32'd42, 1));
    #1 in1 = 32'd9; in2 = 32'd9; funct7 = 7'b0000000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold out %0d", i), out, 32'd42);
      chk($sformatf("hold done %0d", i), 32'(done), 32'd1);
    end

    // Random operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      v.a   = pick_operand();
      v.b   = pick_operand();
      v.f3  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        v.imm = 1'b0;
        v.f7  = 7'b0000001;
      end else begin
        v.imm = 1'($urandom_range(0, 1));
        v.f7  = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom());
        if (!v.imm && v.f7 == 7'b0000001) v.f7 = 7'b0000000;
      end
      v.exp  = ref_result(v.a, v.b, v.imm, v.f3, v.f7);
      v.lat  = ref_latency(v.imm, v.f3, v.f7);
      v.name = $sformatf("rnd%0d f3=%0d f7=%02h imm=%0d a=%08h b=%08h",
                         i, v.f3, v.f7, v.imm, v.a, v.b);
      run_op(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
